// File: rtl/pwm_compare_stage_if.sv
// Duty-value handshake bundle between a duty source and the PWM compare stage.
interface pwm_compare_stage_if #(
  parameter int unsigned DUTY_W = 5
) ();

  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares an upstream free-running count against a
// double-buffered duty value, with period-aligned start/stop sequencing.
module pwm_compare_stage #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DUTY_W = WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 enable,
  pwm_compare_stage_if.slave   duty_if,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 busy
);

  localparam logic [WIDTH-1:0]  MAX_CNT   = '1;
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(2 ** WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_active_q, duty_active_d;
  logic [DUTY_W-1:0] duty_pending_q, duty_pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic              pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              busy_q, busy_d;
  logic              duty_ready_q, duty_ready_d;

  logic              wrap;
  logic              promote;
  logic              accept;
  logic              cmp_hit;
  logic [DUTY_W-1:0] duty_clamped;

  // Next-state, duty buffering and output decode
  always_comb begin
    state_d         = state_q;
    duty_active_d   = duty_active_q;
    duty_pending_d  = duty_pending_q;
    pending_valid_d = pending_valid_q;
    pwm_d           = 1'b0;
    period_start_d  = 1'b0;
    promote         = 1'b0;

    wrap         = (count_in == MAX_CNT);
    cmp_hit      = (DUTY_W'(count_in) < duty_active_q);
    accept       = duty_if.duty_valid && !pending_valid_q;
    duty_clamped = (duty_if.duty_in > DUTY_FULL) ? DUTY_FULL : duty_if.duty_in;

    // Pending duty only moves to active at period boundaries once running
    unique case (state_q)
      S_IDLE:          promote = pending_valid_q;
      S_ARM, S_RUN:    promote = pending_valid_q && wrap;
      default:         promote = 1'b0;
    endcase

    if (promote) begin
      duty_active_d   = duty_pending_q;
      pending_valid_d = 1'b0;
    end

    // Accept and promote are mutually exclusive: accept needs an empty buffer
    if (accept) begin
      duty_pending_d  = duty_clamped;
      pending_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable)   state_d = S_IDLE;
        else if (wrap) state_d = S_RUN;
      end
      S_RUN: begin
        pwm_d          = cmp_hit;
        period_start_d = (count_in == '0);
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        pwm_d = cmp_hit;
        if (enable)    state_d = S_RUN;
        else if (wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    duty_ready_d = !pending_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      duty_active_q   <= '0;
      duty_pending_q  <= '0;
      pending_valid_q <= 1'b0;
      pwm_q           <= 1'b0;
      period_start_q  <= 1'b0;
      busy_q          <= 1'b0;
      duty_ready_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      duty_active_q   <= duty_active_d;
      duty_pending_q  <= duty_pending_d;
      pending_valid_q <= pending_valid_d;
      pwm_q           <= pwm_d;
      period_start_q  <= period_start_d;
      busy_q          <= busy_d;
      duty_ready_q    <= duty_ready_d;
    end
  end

  assign pwm_out            = pwm_q;
  assign period_start       = period_start_q;
  assign busy               = busy_q;
  assign duty_if.duty_ready = duty_ready_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage driving an emulated 4-bit up counter.
module tb_pwm_compare_stage;

  logic       clk;
  logic       reset_n;
  logic [3:0] count_in;
  logic       enable;
  logic       pwm_out;
  logic       period_start;
  logic       busy;
  logic       cnt_run;

  int checks;
  int passed;

  pwm_compare_stage_if #(.DUTY_W(5)) duty_if ();

  pwm_compare_stage #(.WIDTH(4), .DUTY_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .count_in     (count_in),
    .enable       (enable),
    .duty_if      (duty_if.slave),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge; outputs sampled 1 time unit later, then counter advances
  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_run) count_in = count_in + 4'd1;
  endtask

  // Clock through ARM until the edge that samples count 15
  task automatic run_arm(input string name);
    logic [3:0] c;
    bit hit;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      c = count_in;
      tick();
      chk($sformatf("%s arm_pwm c=%0d", name, c), pwm_out, 0);
      chk($sformatf("%s arm_busy c=%0d", name, c), busy, 1);
      if (c == 4'd15) hit = 1;
    end
    chk($sformatf("%s arm_reached_wrap", name), hit, 1);
  endtask

  // One full 16-cycle period at active duty 'duty', with optional duty
  // injection, duplicate valid, disable and re-enable at given counts
  task automatic run_period(input string name, input int duty, input int inj_at,
                            input int inj_val, input int dup_val,
                            input int dis_at, input int re_at);
    logic [3:0] c;
    bit pend;
    int highs;
    int exp_high;
    pend  = 0;
    highs = 0;
    exp_high = (duty > 16) ? 16 : duty;
    for (int i = 0; i < 16; i++) begin
      c = count_in;
      if (int'(c) == dis_at) enable = 1'b0;
      if (int'(c) == re_at)  enable = 1'b1;
      if (int'(c) == inj_at) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = 5'(inj_val);
      end else if (pend && dup_val >= 0 && int'(c) == inj_at + 1) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = 5'(dup_val);
      end
      tick();
      duty_if.duty_valid = 1'b0;
      if (int'(c) == inj_at) pend = 1;
      if (c == 4'd15) pend = 0;
      if (pwm_out === 1'b1) highs++;
      chk($sformatf("%s pwm c=%0d", name, c), pwm_out, (int'(c) < exp_high) ? 1 : 0);
      chk($sformatf("%s period_start c=%0d", name, c), period_start, (c == 4'd0) ? 1 : 0);
      chk($sformatf("%s ready c=%0d", name, c), duty_if.duty_ready, pend ? 0 : 1);
      chk($sformatf("%s busy c=%0d", name, c), busy, (c == 4'd15 && !enable) ? 0 : 1);
    end
    chk($sformatf("%s high_count", name), highs, exp_high);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clk = 1'b0;
    reset_n = 1'b0;
    count_in = 4'd0;
    enable = 1'b0;
    cnt_run = 1'b1;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_in = 5'd0;

    // Reset state
    #12;
    chk("reset pwm", pwm_out, 0);
    chk("reset period_start", period_start, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", duty_if.duty_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Load duty 5 while idle, then enable
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in = 5'd5;
    tick();
    duty_if.duty_valid = 1'b0;
    chk("idle accept ready", duty_if.duty_ready, 0);
    chk("idle accept busy", busy, 0);
    tick();
    chk("idle promote ready", duty_if.duty_ready, 1);
    chk("idle pwm", pwm_out, 0);
    enable = 1'b1;
    run_arm("start");

    // Period sequence: 5 (load 12), 12 (load 16), 16 (load 0 + ignored 3),
    // 0 (load 31 -> 16), 16 (load 8), 8 (disable at 3)
    run_period("p1_d5",  5,  7, 12, -1, -1, -1);
    run_period("p2_d12", 12, 2, 16, -1, -1, -1);
    run_period("p3_d16", 16, 2, 0,   3, -1, -1);
    run_period("p4_d0",  0,  2, 31, -1, -1, -1);
    run_period("p5_d16", 16, 2, 8,  -1, -1, -1);
    run_period("p6_drain", 8, -1, 0, -1, 3, -1);

    // Back in IDLE after drain
    tick();
    chk("post_drain pwm", pwm_out, 0);
    chk("post_drain busy", busy, 0);
    chk("post_drain period_start", period_start, 0);

    // Restart, then drain with re-enable inside the draining period
    enable = 1'b1;
    run_arm("restart");
    run_period("p7_reenable", 8, -1, 0, -1, 3, 10);
    run_period("p8_d8", 8, -1, 0, -1, -1, -1);

    // Async reset while pwm high, with a duty pending
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in = 5'd3;
    tick();
    duty_if.duty_valid = 1'b0;
    chk("pre_reset pwm", pwm_out, 1);
    chk("pre_reset ready", duty_if.duty_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset pwm", pwm_out, 0);
    chk("async_reset period_start", period_start, 0);
    chk("async_reset busy", busy, 0);
    chk("async_reset ready", duty_if.duty_ready, 1);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset pwm %0d", i), pwm_out, 0);
      chk($sformatf("post_reset busy %0d", i), busy, 0);
    end

    // Stuck counter keeps ARM waiting
    cnt_run = 1'b0;
    count_in = 4'd7;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("stuck pwm %0d", i), pwm_out, 0);
      chk($sformatf("stuck busy %0d", i), busy, 1);
    end
    cnt_run = 1'b1;
    run_arm("unstuck");

    // Active and pending duty were both discarded by reset
    run_period("p9_cleared", 0, -1, 0, -1, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
PWM generator that consumes the free-running count produced by the 4-bit synchronous up counter (count 0..15, wraps). It compares the sampled count against a double-buffered duty value and drives a registered PWM output. A small FSM aligns start and stop to period boundaries. New duty values arrive over a valid/ready handshake.

Parameters:
WIDTH, 4, width of count_in; period = 2^WIDTH cycles; MAX = 2^WIDTH-1
DUTY_W, WIDTH+1, width of duty_in; legal duty 0..2^WIDTH (2^WIDTH = always high)

Ports:
clk  input  1  rising-edge clock shared with the upstream counter
reset_n  input  1  asynchronous, active-low reset
count_in  input  WIDTH  count value from the upstream up counter
enable  input  1  request PWM operation
duty_in  input  DUTY_W  new duty value (high cycles per period)
duty_valid  input  1  duty_in valid
duty_ready  output  1  block can accept duty_in
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse marking count 0 of each active period
busy  output  1  high when FSM is not IDLE

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low. Assertion forces all state immediately, without waiting for clk.
- Reset values: state=IDLE, duty_active=0, duty_pending=0, pending_valid=0, pwm_out=0, period_start=0. Therefore duty_ready=1 and busy=0.
- "c" = count_in sampled at a rising edge. "wrap" = (c == MAX).
- Handshake:
  - duty_ready = !pending_valid.
  - Transfer occurs when duty_valid && duty_ready at an edge. It loads duty_pending (values above 2^WIDTH clamp to 2^WIDTH) and sets pending_valid.
  - duty_valid is ignored while duty_ready=0. No data is lost or overwritten.
- Pending to active:
  - In IDLE: at any edge with pending_valid.
  - In ARM or RUN: only at a wrap edge.
  - In DRAIN: never.
  - Each pending-to-active move clears pending_valid, so duty_ready returns high the next cycle.
- FSM:
  - IDLE: pwm_out<=0. enable=1 -> ARM.
  - ARM: pwm_out<=0. enable=0 -> IDLE. Wrap -> RUN.
  - RUN: pwm_out <= (c < duty_active), using duty_active before any same-edge update. enable=0 -> DRAIN, and that edge still performs the RUN compare.
  - DRAIN: pwm_out <= (c < duty_active). enable=1 -> RUN with no gap. Wrap -> IDLE, and that edge still compares, completing the period. The first IDLE edge drives pwm_out to 0.
- period_start <= (state==RUN && c==0). Otherwise 0. It is high in the same cycle pwm_out reflects count 0.
- Latency:
  - pwm_out reflects the count sampled one edge earlier.
  - A duty change takes effect on the first count 0 after the next wrap.
- Duty edge cases:
  - duty 0: pwm_out always 0 in RUN.
  - duty 2^WIDTH: pwm_out always 1 in RUN.
  - duty d: exactly d high cycles per 2^WIDTH-cycle period.
- count_in is used by value only. Non-sequential values are compared as-is. A missing MAX keeps ARM waiting and DRAIN running.
- Reset mid-operation:
  - pwm_out drops to 0 immediately and the FSM returns to IDLE.
  - Pending and active duty are discarded.

Test Plan:
- Reset during RUN with pwm_out=1 -> pwm_out, period_start and busy go 0 asynchronously; duty_ready=1; after release, stays IDLE with pwm_out=0 until enable.
- In IDLE, send duty 5 (valid held 1 cycle), enable=1, counter free-running -> ARM until c=15; then each 16-cycle period has pwm_out high 5 cycles (counts 0..4). period_start pulses once per period, coincident with the first high cycle.
- In RUN at duty 5, send duty 12 at c=7 -> duty_ready low until the wrap edge; remainder of the period uses 5; next period has 12 high cycles; duty_ready high again the cycle after the wrap.
- Send duty 16, then duty 0, then duty 31 (clamped to 16) on successive periods -> pwm_out all-high, all-low, all-high; a second valid while ready=0 is ignored.
- Deassert enable at c=3 with duty 8 -> that period completes (8 high cycles), then IDLE with pwm_out=0. Re-assert at c=10 within DRAIN -> RUN continues with no missing period_start.
- enable=1 with count_in stuck at 7 -> stays ARM, pwm_out=0, busy=1. Release counter -> RUN after the first sampled 15.
